// File: rtl/frame_write_arbiter.sv
// ---------------------------------------------------------------------------
// frame_write_arbiter
//
// Owns the single write port of the 176x144 RGB332 frame-buffer DP RAM and
// shares it between three writers with fixed priority:
//   camera capture (no backpressure) > clear engine > host (req/ack).
// Live/frozen capture changes only on vsync rising edges, so a displayed
// frame is never half-updated.
//
// Optional feature (macro FRAME_WRITE_ARBITER_STATS_EN): adds saturating
// statistics outputs cam_drop_cnt and host_wait_cnt.
//
// Ports
//   pclk, rst_n            pixel clock, synchronous active-low reset
//   vsync                  camera vsync, rising edge = frame boundary
//   cam_we/addr/data       capture write strobe, address, pixel
//   host_req/addr/data     host write request (held until ack), address, pixel
//   host_ack               one-cycle pulse, host write accepted
//   freeze                 level, 1 = stop camera updates at next boundary
//   clear_start            pulse, start full-frame clear
//   clear_busy             clear engine running
//   frozen                 camera writes currently blocked
//   frame_cnt              live frames accepted (wraps)
//   ram_we/addr/data       registered DP RAM write port
//   cam_drop_cnt           (stats) cam_we cycles while frozen, saturating
//   host_wait_cnt          (stats) host_req cycles without a win, saturating
// ---------------------------------------------------------------------------
module frame_write_arbiter #(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned FRAME_PIXELS = 25344,
  parameter logic [7:0]  CLEAR_COLOR  = 8'h00
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              cam_we,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [7:0]        cam_data,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_data,
  output logic              host_ack,
  input  logic              freeze,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              frozen,
  output logic [7:0]        frame_cnt,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
`ifdef FRAME_WRITE_ARBITER_STATS_EN
  output logic [15:0]       cam_drop_cnt,
  output logic [15:0]       host_wait_cnt,
`endif
  output logic [7:0]        ram_data
);

  typedef enum logic {
    CAP_LIVE,
    CAP_FROZEN
  } cap_state_e;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_e;

  // State registers
  cap_state_e        cap_q, cap_d;
  clr_state_e        clr_q, clr_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              vsync_q;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  // Registered write port
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_data_q, ram_data_d;
  logic              host_ack_q, host_ack_d;

  // Per-cycle arbitration
  logic fb;
  logic cam_en;
  logic cam_win;
  logic clr_win;
  logic host_win;
  logic win_valid;

  assign fb       = vsync & ~vsync_q;
  assign cam_en   = (cap_q == CAP_LIVE);
  // A camera write while frozen is dropped, leaving the slot free below.
  assign cam_win  = cam_we & cam_en;
  assign clr_win  = (clr_q == CLR_RUN) & ~cam_win;
  assign host_win = host_req & ~cam_win & ~clr_win;

  // Capture sequencing: freeze is only looked at on a frame boundary.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    cap_d       = cap_q;
    frame_cnt_d = frame_cnt_q;
    if (fb) begin
      if (freeze) begin
        cap_d = CAP_FROZEN;
      end else begin
        cap_d       = CAP_LIVE;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  // Clear engine: the counter only moves on slots the engine actually wins.
  always_comb begin
    clr_d     = clr_q;
    clr_cnt_d = clr_cnt_q;
    unique case (clr_q)
      CLR_IDLE: begin
        if (clear_start) begin
          clr_d     = CLR_RUN;
          clr_cnt_d = '0;
        end
      end
      CLR_RUN: begin
        // clear_start is ignored here: a running clear is never restarted.
        if (clr_win) begin
          if (32'(clr_cnt_q) == FRAME_PIXELS - 1) begin
            clr_d     = CLR_IDLE;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        clr_d     = CLR_IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Write mux. Address/data hold their last value in idle slots; an
  // out-of-range winner still shows its address/data but with ram_we low.
  always_comb begin
    win_valid  = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    if (cam_win) begin
      win_valid  = 1'b1;
      ram_addr_d = cam_addr;
      ram_data_d = cam_data;
    end else if (clr_win) begin
      win_valid  = 1'b1;
      ram_addr_d = clr_cnt_q;
      ram_data_d = CLEAR_COLOR;
    end else if (host_win) begin
      win_valid  = 1'b1;
      ram_addr_d = host_addr;
      ram_data_d = host_data;
    end
    ram_we_d   = win_valid & (32'(ram_addr_d) < FRAME_PIXELS);
    // The host is acked even for a discarded address so it can never hang.
    host_ack_d = host_win;
  end

  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      cap_q       <= CAP_LIVE;
      clr_q       <= CLR_IDLE;
      clr_cnt_q   <= '0;
      vsync_q     <= 1'b0;
      frame_cnt_q <= 8'd0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= 8'd0;
      host_ack_q  <= 1'b0;
    end else begin
      cap_q       <= cap_d;
      clr_q       <= clr_d;
      clr_cnt_q   <= clr_cnt_d;
      vsync_q     <= vsync;
      frame_cnt_q <= frame_cnt_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      host_ack_q  <= host_ack_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign host_ack   = host_ack_q;
  assign clear_busy = (clr_q == CLR_RUN);
  assign frozen     = (cap_q == CAP_FROZEN);
  assign frame_cnt  = frame_cnt_q;

`ifdef FRAME_WRITE_ARBITER_STATS_EN
  logic [15:0] cam_drop_q, cam_drop_d;
  logic [15:0] host_wait_q, host_wait_d;

  always_comb begin
    cam_drop_d  = cam_drop_q;
    host_wait_d = host_wait_q;
    if (cam_we && !cam_en && cam_drop_q != 16'hFFFF) begin
      cam_drop_d = cam_drop_q + 16'd1;
    end
    if (host_req && !host_win && host_wait_q != 16'hFFFF) begin
      host_wait_d = host_wait_q + 16'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      cam_drop_q  <= 16'd0;
      host_wait_q <= 16'd0;
    end else begin
      cam_drop_q  <= cam_drop_d;
      host_wait_q <= host_wait_d;
    end
  end

  assign cam_drop_cnt  = cam_drop_q;
  assign host_wait_cnt = host_wait_q;
`endif

endmodule

// File: tb/tb_frame_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_frame_write_arbiter
//
// Randomized and directed stimulus against a cycle-level reference model of
// the frame write arbiter. The model tracks capture as a live flag, the clear
// engine as a single integer position (-1 when idle) and predicts the write
// port one cycle after each sampled input set.
// ---------------------------------------------------------------------------
module tb_frame_write_arbiter;

  localparam int ADDR_W       = 15;
  localparam int FRAME_PIXELS = 25344;

  logic              pclk = 1'b0;
  logic              rst_n;
  logic              vsync;
  logic              cam_we;
  logic [ADDR_W-1:0] cam_addr;
  logic [7:0]        cam_data;
  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_data;
  logic              host_ack;
  logic              freeze;
  logic              clear_start;
  logic              clear_busy;
  logic              frozen;
  logic [7:0]        frame_cnt;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
`ifdef FRAME_WRITE_ARBITER_STATS_EN
  logic [15:0]       cam_drop_cnt;
  logic [15:0]       host_wait_cnt;
`endif

  frame_write_arbiter dut (
    .pclk         (pclk),
    .rst_n        (rst_n),
    .vsync        (vsync),
    .cam_we       (cam_we),
    .cam_addr     (cam_addr),
    .cam_data     (cam_data),
    .host_req     (host_req),
    .host_addr    (host_addr),
    .host_data    (host_data),
    .host_ack     (host_ack),
    .freeze       (freeze),
    .clear_start  (clear_start),
    .clear_busy   (clear_busy),
    .frozen       (frozen),
    .frame_cnt    (frame_cnt),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
`ifdef FRAME_WRITE_ARBITER_STATS_EN
    .cam_drop_cnt (cam_drop_cnt),
    .host_wait_cnt(host_wait_cnt),
`endif
    .ram_data     (ram_data)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit m_live;
  int m_clr;      // next clear address, -1 when idle
  int m_frames;
  bit m_vs;
  int m_drop;
  int m_wait;
  // Predicted outputs after the coming edge
  bit e_we;
  bit e_ack;
  bit e_cmp;      // address/data are meaningful this cycle
  int e_addr;
  int e_data;

  // Predict from the inputs currently applied, advance one clock, compare.
  task automatic step();
    bit cam_w, clr_w, host_w;
    int addr, data;
    if (!rst_n) begin
      m_live = 1; m_clr = -1; m_frames = 0; m_vs = 0; m_drop = 0; m_wait = 0;
      e_we = 0; e_ack = 0; e_cmp = 1; e_addr = 0; e_data = 0;
    end else begin
      cam_w  = cam_we && m_live;
      clr_w  = !cam_w && (m_clr >= 0);
      host_w = host_req && !cam_w && !clr_w;
      addr   = cam_w ? int'(cam_addr) : clr_w ? m_clr : int'(host_addr);
      data   = cam_w ? int'(cam_data) : clr_w ? 0 : int'(host_data);
      e_cmp  = cam_w || clr_w || host_w;
      e_we   = e_cmp && (addr < FRAME_PIXELS);
      e_ack  = host_w;
      if (e_cmp) begin
        e_addr = addr;
        e_data = data;
      end
      if (cam_we && !m_live && m_drop < 65535) m_drop++;
      if (host_req && !host_w && m_wait < 65535) m_wait++;
      if (clr_w) m_clr = (m_clr == FRAME_PIXELS - 1) ? -1 : m_clr + 1;
      else if (m_clr < 0 && clear_start) m_clr = 0;
      if (vsync && !m_vs) begin
        m_live = !freeze;
        if (m_live) m_frames = (m_frames + 1) % 256;
      end
      m_vs = vsync;
    end
    @(posedge pclk);
    #1;
    check("ram_we", ram_we, e_we);
    check("host_ack", host_ack, e_ack);
    if (e_cmp) begin
      check("ram_addr", ram_addr, e_addr);
      check("ram_data", ram_data, e_data);
    end
    check("clear_busy", clear_busy, m_clr >= 0);
    check("frozen", frozen, !m_live);
    check("frame_cnt", frame_cnt, m_frames);
`ifdef FRAME_WRITE_ARBITER_STATS_EN
    check("cam_drop_cnt", cam_drop_cnt, m_drop);
    check("host_wait_cnt", host_wait_cnt, m_wait);
`endif
  endtask

  initial begin
    bit done;
    int n_wr, n_busy;

    rst_n = 0; vsync = 0; cam_we = 0; cam_addr = '0; cam_data = '0;
    host_req = 0; host_addr = '0; host_data = '0; freeze = 0; clear_start = 0;
    step();
    step();
    check("rst_ram_we", ram_we, 0);
    check("rst_frozen", frozen, 0);
    rst_n = 1;

    // Single camera write, one cycle latency
    cam_we = 1; cam_addr = 15'd100; cam_data = 8'hE3;
    step();
    check("t1_ram_we", ram_we, 1);
    check("t1_ram_addr", ram_addr, 100);
    check("t1_ram_data", ram_data, 8'hE3);

    // Camera blocks host for three cycles, then host is served
    host_req = 1; host_addr = 15'd5; host_data = 8'h1C;
    for (int i = 0; i < 3; i++) begin
      cam_addr = 15'($urandom_range(FRAME_PIXELS - 1, 0));
      cam_data = 8'($urandom);
      step();
      check("t2_no_ack", host_ack, 0);
    end
    cam_we = 0;
    step();
    check("t2_ack", host_ack, 1);
    check("t2_addr", ram_addr, 5);
    check("t2_data", ram_data, 8'h1C);
    host_req = 0;
    step();

    // Four more blocked host cycles
    cam_we = 1; host_req = 1; host_addr = 15'd7; host_data = 8'h55;
    for (int i = 0; i < 4; i++) step();
    cam_we = 0;
    step();
    host_req = 0;
`ifdef FRAME_WRITE_ARBITER_STATS_EN
    check("t6_host_wait", host_wait_cnt, 3 + 4);
`endif

    // Freeze takes effect only at the vsync rise
    cam_we = 1; freeze = 1;
    for (int i = 0; i < 4; i++) begin
      cam_addr = 15'($urandom_range(FRAME_PIXELS - 1, 0));
      cam_data = 8'($urandom);
      step();
    end
    check("t3_live_mid_frame", frozen, 0);
    vsync = 1;
    step();
    check("t3_frozen", frozen, 1);
    check("t3_cnt_frozen_fb", frame_cnt, 0);
    vsync = 0;
    for (int i = 0; i < 10; i++) begin
      cam_addr = 15'($urandom_range(FRAME_PIXELS - 1, 0));
      step();
      check("t3_dropped", ram_we, 0);
    end
`ifdef FRAME_WRITE_ARBITER_STATS_EN
    check("t6_cam_drop", cam_drop_cnt, 10);
`endif
    cam_we = 0; freeze = 0;
    for (int i = 0; i < 3; i++) step();
    check("t3_still_frozen", frozen, 1);
    vsync = 1;
    step();
    check("t3_live_again", frozen, 0);
    check("t3_cnt_live_fb", frame_cnt, 1);
    vsync = 0;
    step();

    // Out-of-range host address: acked, not written
    host_req = 1; host_addr = 15'(FRAME_PIXELS); host_data = 8'hAA;
    step();
    check("t5_range_ack", host_ack, 1);
    check("t5_range_we", ram_we, 0);
    host_req = 0;
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(399, 0) != 0);
      if ($urandom_range(29, 0) == 0) vsync = ~vsync;
      if ($urandom_range(59, 0) == 0) freeze = ~freeze;
      cam_we   = $urandom_range(1, 0) == 1;
      cam_addr = 15'($urandom_range(FRAME_PIXELS + 60, 0));
      cam_data = 8'($urandom);
      clear_start = ($urandom_range(799, 0) == 0);
      if (host_req && host_ack) begin
        host_req = 0;
      end else if (!host_req && $urandom_range(3, 0) == 0) begin
        host_req  = 1;
        host_addr = 15'($urandom_range(FRAME_PIXELS + 60, 0));
        host_data = 8'($urandom);
      end
      step();
    end

    // Reset to a quiet state
    rst_n = 0; vsync = 0; cam_we = 0; host_req = 0; freeze = 0; clear_start = 0;
    step();
    rst_n = 1;
    step();

    // Full-frame clear with a restart attempt mid-run
    clear_start = 1;
    step();
    clear_start = 0;
    n_busy = clear_busy ? 1 : 0;
    n_wr = 0;
    done = 0;
    for (int i = 0; i < 30000 && !done; i++) begin
      clear_start = (i == 5000);
      step();
      if (ram_we) n_wr++;
      if (clear_busy) n_busy++;
      else done = 1;
    end
    clear_start = 0;
    check("t4_done", done, 1);
    check("t4_writes", n_wr, FRAME_PIXELS);
    check("t4_busy_cycles", n_busy, FRAME_PIXELS);
    step();

    // Reset in the middle of a clear
    clear_start = 1;
    step();
    clear_start = 0;
    for (int i = 0; i < 1100 && m_clr != 1000; i++) step();
    check("t5_reached_1000", m_clr, 1000);
    rst_n = 0;
    step();
    check("t5_busy_in_rst", clear_busy, 0);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_no_clear_we", ram_we, 0);
    end
    check("t5_busy_after_rst", clear_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
